fmt2_exec: RTL and testbench

- Sequencer for MSP430 format-II single-operand shift/byte instructions: RRC, RRA, SWPB, SXT.
- Fetches the operand through the four source addressing modes and presents it to the shifter as FS/BW/DST.
- Captures SHIFT_OUT/CVNZ_shift, writes the result back to the register file or memory, and issues the status-register update.

---
 rtl/fmt2_exec.sv | 228 ++++++++++++++++++++++
 tb/tb_fmt2_exec.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmt2_exec.sv
// fmt2_exec: MSP430 format-II RRC/RRA/SWPB/SXT sequencer.
// Fetches the operand, drives the shifter, writes back result and flags.
module fmt2_exec #(
  parameter int SIZE_BYTE = 8,
  parameter int SIZE_WORD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [SIZE_WORD-1:0] IR,
  input  logic [SIZE_WORD-1:0] EXT,
  output logic [3:0]           RF_ADDR,
  input  logic [SIZE_WORD-1:0] RF_RDATA,
  output logic                 RF_WE,
  output logic [SIZE_WORD-1:0] RF_WDATA,
  output logic                 MEM_REQ,
  output logic                 MEM_WE,
  output logic [SIZE_WORD-1:0] MEM_ADDR,
  output logic [1:0]           MEM_BE,
  output logic [SIZE_WORD-1:0] MEM_WDATA,
  input  logic [SIZE_WORD-1:0] MEM_RDATA,
  input  logic                 MEM_ACK,
  output logic [1:0]           FS,
  output logic                 BW,
  output logic [SIZE_WORD-1:0] DST,
  input  logic [SIZE_WORD-1:0] SHIFT_OUT,
  input  logic [3:0]           CVNZ_shift,
  output logic                 SR_WE,
  output logic [3:0]           SR_CVNZ,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ILLEGAL
);

  localparam int W = SIZE_WORD;
  localparam int B = SIZE_BYTE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDREG,
    S_ADDR,
    S_MEMRD,
    S_EXEC,
    S_WBREG,
    S_MEMWR,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] opc;
    logic       bw;
    logic [1:0] as_m;
    logic [3:0] rn;
    logic       ill;
  } dec_t;

  state_t state, state_n;
  dec_t   dec_d, dec_q;

  logic [W-1:0] ext_q;
  logic [W-1:0] base_q;
  logic [W-1:0] ea_q;
  logic [W-1:0] opnd_q;
  logic [W-1:0] res_q;

  logic [W-1:0] ea_n;
  logic [W-1:0] inc;
  logic [B-1:0] rd_byte;
  logic [W-1:0] rd_opnd;
  logic [W-1:0] rf_opnd;
  logic [W-1:0] wb_data;
  logic [W-1:0] wr_data;
  logic [W-1:0] mem_addr;
  logic [1:0]   wr_be;
  logic         sr_upd;

  always_comb begin
    dec_d.opc  = IR[9:7];
    dec_d.bw   = IR[6];
    dec_d.as_m = IR[5:4];
    dec_d.rn   = IR[3:0];
    dec_d.ill  = (IR[15:10] != 6'b000100)
               | IR[9]
               | (IR[6] & IR[7])
               | (IR[3:0] == 4'd3)
               | ((IR[3:0] == 4'd2) & IR[5]);
  end

  // Indexed mode on R2 (the status register) means absolute addressing.
  always_comb begin
    ea_n = base_q;
    unique case (1'b1)
      (dec_q.as_m == 2'b01) && (dec_q.rn == 4'd2):
        ea_n = ext_q;
      (dec_q.as_m == 2'b01) && (dec_q.rn != 4'd2):
        ea_n = base_q + ext_q;
      default:
        ea_n = base_q;
    endcase
  end

  // SP and PC always step by 2, even for byte operations.
  assign inc = (dec_q.bw && (dec_q.rn >= 4'd2)) ? W'(1) : W'(2);

  assign rd_byte = ea_q[0] ? MEM_RDATA[W-1:B]
                           : MEM_RDATA[B-1:0];

  assign rd_opnd = dec_q.bw ? {{(W-B){1'b0}}, rd_byte}
                            : MEM_RDATA;

  assign rf_opnd = dec_q.bw ? {{(W-B){1'b0}}, RF_RDATA[B-1:0]}
                            : RF_RDATA;

  assign wb_data = dec_q.bw ? {{(W-B){1'b0}}, res_q[B-1:0]}
                            : res_q;

  assign wr_data = dec_q.bw ? {res_q[B-1:0], res_q[B-1:0]}
                            : res_q;

  assign wr_be = dec_q.bw ? (ea_q[0] ? 2'b10 : 2'b01)
                          : 2'b11;

  assign mem_addr = {ea_q[W-1:1], 1'b0};
  assign sr_upd   = (dec_q.opc != 3'b001);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      dec_q  <= '0;
      ext_q  <= '0;
      base_q <= '0;
      ea_q   <= '0;
      opnd_q <= '0;
      res_q  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            dec_q <= dec_d;
            ext_q <= EXT;
          end
        end
        S_RDREG: begin
          base_q <= RF_RDATA;
          if (dec_q.as_m == 2'b00) opnd_q <= rf_opnd;
        end
        S_ADDR:  ea_q <= ea_n;
        S_MEMRD: if (MEM_ACK) opnd_q <= rd_opnd;
        S_EXEC:  res_q <= SHIFT_OUT;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    RF_ADDR   = '0;
    RF_WE     = 1'b0;
    RF_WDATA  = '0;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_BE    = 2'b00;
    MEM_WDATA = '0;
    FS        = 2'b00;
    BW        = 1'b0;
    DST       = '0;
    SR_WE     = 1'b0;
    SR_CVNZ   = 4'b0000;
    DONE      = 1'b0;
    ILLEGAL   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START) state_n = dec_d.ill ? S_DONE : S_RDREG;
      end
      S_RDREG: begin
        RF_ADDR = dec_q.rn;
        state_n = (dec_q.as_m == 2'b00) ? S_EXEC : S_ADDR;
      end
      S_ADDR: begin
        if (dec_q.as_m == 2'b11) begin
          RF_WE    = 1'b1;
          RF_ADDR  = dec_q.rn;
          RF_WDATA = base_q + inc;
        end
        state_n = S_MEMRD;
      end
      S_MEMRD: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = mem_addr;
        MEM_BE   = 2'b11;
        if (MEM_ACK) state_n = S_EXEC;
      end
      S_EXEC: begin
        FS      = {dec_q.opc[0], dec_q.opc[1]};
        BW      = dec_q.bw;
        DST     = opnd_q;
        SR_WE   = sr_upd;
        SR_CVNZ = sr_upd ? CVNZ_shift : 4'b0000;
        state_n = (dec_q.as_m == 2'b00) ? S_WBREG : S_MEMWR;
      end
      S_WBREG: begin
        RF_WE    = 1'b1;
        RF_ADDR  = dec_q.rn;
        RF_WDATA = wb_data;
        state_n  = S_DONE;
      end
      S_MEMWR: begin
        MEM_REQ   = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADDR  = mem_addr;
        MEM_BE    = wr_be;
        MEM_WDATA = wr_data;
        if (MEM_ACK) state_n = S_DONE;
      end
      S_DONE: begin
        DONE    = 1'b1;
        ILLEGAL = dec_q.ill;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_fmt2_exec.sv
// tb_fmt2_exec: scoreboard bench for the format-II sequencer.
// Models register file, memory with wait states, and the shifter.
module tb_fmt2_exec;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [15:0] IR;
  logic [15:0] EXT;
  logic [3:0]  RF_ADDR;
  logic [15:0] RF_RDATA;
  logic        RF_WE;
  logic [15:0] RF_WDATA;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_WDATA;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [1:0]  FS;
  logic        BW;
  logic [15:0] DST;
  logic [15:0] SHIFT_OUT;
  logic [3:0]  CVNZ_shift;
  logic        SR_WE;
  logic [3:0]  SR_CVNZ;
  logic        BUSY;
  logic        DONE;
  logic        ILLEGAL;

  fmt2_exec #(.SIZE_BYTE(8), .SIZE_WORD(16)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .IR(IR), .EXT(EXT),
    .RF_ADDR(RF_ADDR), .RF_RDATA(RF_RDATA),
    .RF_WE(RF_WE), .RF_WDATA(RF_WDATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK),
    .FS(FS), .BW(BW), .DST(DST),
    .SHIFT_OUT(SHIFT_OUT), .CVNZ_shift(CVNZ_shift),
    .SR_WE(SR_WE), .SR_CVNZ(SR_CVNZ),
    .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL)
  );

  localparam int K_RF  = 0;
  localparam int K_MRD = 1;
  localparam int K_MWR = 2;
  localparam int K_SR  = 3;
  localparam int K_DN  = 4;

  typedef struct {
    int         kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  aux;
  } ev_t;

  ev_t sb[$];

  logic [15:0] rf [0:15];
  logic [15:0] mem [0:1023];

  int   cyc = 0;
  int   start_cyc = 0;
  int   mem_wait = 0;
  int   wcnt = 0;
  logic sr_c = 1'b0;

  logic        pl_en = 1'b0;
  logic        pl_mem = 1'b0;
  logic [15:0] pl_a = '0;
  logic [15:0] pl_d = '0;

  int mon_chk = 0;
  int mon_pass = 0;
  int st_chk = 0;
  int st_pass = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (SR_WE) sr_c <= SR_CVNZ[3];
  end

  always @(posedge CLK) begin
    if (RF_WE) rf[RF_ADDR] <= RF_WDATA;
    else if (pl_en && !pl_mem) rf[pl_a[3:0]] <= pl_d;
  end

  assign RF_RDATA = rf[RF_ADDR];

  // Shifter reference following the MSP430 ISA flag rules.
  logic [15:0] sh_r;
  logic        sh_c, sh_n, sh_z;
  always_comb begin
    sh_r = '0;
    sh_c = 1'b0;
    case (FS)
      2'b00: begin
        sh_r = BW ? {8'h00, sr_c, DST[7:1]} : {sr_c, DST[15:1]};
        sh_c = DST[0];
      end
      2'b01: begin
        sh_r = BW ? {8'h00, DST[7], DST[7:1]} : {DST[15], DST[15:1]};
        sh_c = DST[0];
      end
      2'b10: sh_r = {DST[7:0], DST[15:8]};
      default: sh_r = {{8{DST[7]}}, DST[7:0]};
    endcase
    sh_n = BW ? sh_r[7] : sh_r[15];
    sh_z = BW ? (sh_r[7:0] == 8'h00) : (sh_r == 16'h0000);
    if (FS == 2'b11) sh_c = ~sh_z;
    SHIFT_OUT  = sh_r;
    CVNZ_shift = {sh_c, 1'b0, sh_n, sh_z};
  end

  initial begin
    MEM_ACK = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (MEM_ACK) begin
        MEM_ACK = 1'b0;
        wcnt = 0;
      end else if (MEM_REQ) begin
        if (wcnt >= mem_wait) begin
          MEM_ACK = 1'b1;
          if (MEM_WE) begin
            if (MEM_BE[0]) mem[MEM_ADDR[10:1]][7:0] = MEM_WDATA[7:0];
            if (MEM_BE[1]) mem[MEM_ADDR[10:1]][15:8] = MEM_WDATA[15:8];
          end else begin
            MEM_RDATA = mem[MEM_ADDR[10:1]];
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      if (pl_en && pl_mem) mem[pl_a[10:1]] = pl_d;
    end
  end

  task automatic mon_cmp(input int k, input logic [15:0] a,
                         input logic [15:0] d, input logic [1:0] x,
                         input string nm);
    ev_t e;
    logic ok;
    mon_chk++;
    if (sb.size() == 0) begin
      $display("FAIL %s: got unexpected addr=%h data=%h aux=%b, required none",
               nm, a, d, x);
    end else begin
      e = sb.pop_front();
      ok = (e.kind == k) && (e.addr == a) && (e.aux == x);
      if (!(k == K_DN && e.data == 16'hFFFF)) ok = ok && (e.data == d);
      if (ok) mon_pass++;
      else $display("FAIL %s: got k=%0d a=%h d=%h x=%b, required k=%0d a=%h d=%h x=%b",
                    nm, k, a, d, x, e.kind, e.addr, e.data, e.aux);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (RF_WE)
        mon_cmp(K_RF, {12'h000, RF_ADDR}, RF_WDATA, 2'b00, "rf_write");
      if (MEM_REQ && MEM_ACK && !MEM_WE)
        mon_cmp(K_MRD, MEM_ADDR, 16'h0000, MEM_BE, "mem_read");
      if (MEM_REQ && MEM_ACK && MEM_WE)
        mon_cmp(K_MWR, MEM_ADDR, MEM_WDATA, MEM_BE, "mem_write");
      if (SR_WE)
        mon_cmp(K_SR, 16'h0000, {12'h000, SR_CVNZ}, 2'b00, "sr_update");
      if (DONE)
        mon_cmp(K_DN, 16'h0000, 16'(cyc - start_cyc + 1),
                {1'b0, ILLEGAL}, "done");
    end
  end

  task automatic expect_ev(input int k, input logic [15:0] a,
                           input logic [15:0] d, input logic [1:0] x);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    e.aux  = x;
    sb.push_back(e);
  endtask

  task automatic st_check(input string nm, input logic [15:0] act,
                          input logic [15:0] req);
    st_chk++;
    if (act === req) st_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  task automatic preload(input logic m, input logic [15:0] a,
                         input logic [15:0] d);
    @(negedge CLK);
    pl_mem = m;
    pl_a = a;
    pl_d = d;
    pl_en = 1'b1;
    @(negedge CLK);
    pl_en = 1'b0;
  endtask

  task automatic start_instr(input logic [15:0] ir, input logic [15:0] ext);
    @(negedge CLK);
    IR = ir;
    EXT = ext;
    START = 1'b1;
    start_cyc = cyc + 1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic finish_instr(input string nm, input int budget);
    int n;
    n = 0;
    while (!DONE && n < budget) begin
      @(negedge CLK);
      n++;
    end
    st_check({nm, "_done"}, 16'(DONE), 16'd1);
    @(negedge CLK);
    #1;
    st_check({nm, "_drain"}, 16'(sb.size()), 16'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    RST = 1'b1;
    START = 1'b0;
    IR = '0;
    EXT = '0;
    #1;
    st_check("reset_ctl",
             {BUSY, DONE, ILLEGAL, MEM_REQ, MEM_WE, RF_WE, SR_WE, BW,
              FS, MEM_BE, RF_ADDR}, 16'h0000);
    st_check("reset_data", DST | MEM_ADDR | RF_WDATA | MEM_WDATA
             | {12'h000, SR_CVNZ}, 16'h0000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    preload(1'b0, 16'd5, 16'h8003);
    preload(1'b0, 16'd6, 16'h0200);
    preload(1'b0, 16'd7, 16'h0300);
    preload(1'b0, 16'd1, 16'h0101);
    preload(1'b0, 16'd8, 16'h0210);
    preload(1'b0, 16'd9, 16'h12FE);
    preload(1'b0, 16'd10, 16'h0220);
    preload(1'b1, 16'h0200, 16'h1234);
    preload(1'b1, 16'h0304, 16'hAB81);
    preload(1'b1, 16'h0100, 16'h80FF);
    preload(1'b1, 16'h0210, 16'h0080);

    // RRA.W R5
    expect_ev(K_SR, 16'h0, 16'h000A, 2'b00);
    expect_ev(K_RF, 16'd5, 16'hC001, 2'b00);
    expect_ev(K_DN, 16'h0, 16'd4, 2'b00);
    start_instr(16'h1105, 16'h0000);
    finish_instr("rra_w_reg", 20);

    // SWPB @R6+ with two wait states
    mem_wait = 2;
    expect_ev(K_RF, 16'd6, 16'h0202, 2'b00);
    expect_ev(K_MRD, 16'h0200, 16'h0000, 2'b11);
    expect_ev(K_MWR, 16'h0200, 16'h3412, 2'b11);
    expect_ev(K_DN, 16'h0, 16'hFFFF, 2'b00);
    start_instr(16'h10B6, 16'h0000);
    finish_instr("swpb_postinc", 40);
    st_check("swpb_mem", mem[10'h100], 16'h3412);
    st_check("swpb_r6", rf[6], 16'h0202);

    // RRA.B 5(R7), zero wait states, odd EA
    mem_wait = 0;
    expect_ev(K_MRD, 16'h0304, 16'h0000, 2'b11);
    expect_ev(K_SR, 16'h0, 16'h000A, 2'b00);
    expect_ev(K_MWR, 16'h0304, 16'hD5D5, 2'b10);
    expect_ev(K_DN, 16'h0, 16'hFFFF, 2'b00);
    start_instr(16'h1157, 16'h0005);
    finish_instr("rra_b_idx", 40);
    st_check("rra_b_idx_mem", mem[10'h182], 16'hD581);

    // RRA.B @R1+: SP steps by 2, byte from original odd EA
    mem_wait = 1;
    expect_ev(K_RF, 16'd1, 16'h0103, 2'b00);
    expect_ev(K_MRD, 16'h0100, 16'h0000, 2'b11);
    expect_ev(K_SR, 16'h0, 16'h0002, 2'b00);
    expect_ev(K_MWR, 16'h0100, 16'hC0C0, 2'b10);
    expect_ev(K_DN, 16'h0, 16'hFFFF, 2'b00);
    start_instr(16'h1171, 16'h0000);
    finish_instr("rra_b_sp", 40);
    st_check("rra_b_sp_mem", mem[10'h080], 16'hC0FF);

    // SXT.B is illegal
    expect_ev(K_DN, 16'h0, 16'd1, 2'b01);
    start_instr(16'h11C5, 16'h0000);
    finish_instr("sxt_b_ill", 10);

    // SXT @R8 with a second START while busy
    mem_wait = 3;
    expect_ev(K_MRD, 16'h0210, 16'h0000, 2'b11);
    expect_ev(K_SR, 16'h0, 16'h000A, 2'b00);
    expect_ev(K_MWR, 16'h0210, 16'hFF80, 2'b11);
    expect_ev(K_DN, 16'h0, 16'hFFFF, 2'b00);
    start_instr(16'h11A8, 16'h0000);
    @(negedge CLK);
    IR = 16'h1009;
    START = 1'b1;
    st_check("busy_on_start2", 16'(BUSY), 16'd1);
    @(negedge CLK);
    START = 1'b0;
    finish_instr("sxt_w_ind", 40);
    repeat (6) @(negedge CLK);
    #1;
    st_check("single_done", 16'(sb.size()) | 16'(BUSY), 16'd0);
    st_check("sxt_mem", mem[10'h108], 16'hFF80);

    // RRC.B R9 uses C=1 left by SXT
    expect_ev(K_SR, 16'h0, 16'h0002, 2'b00);
    expect_ev(K_RF, 16'd9, 16'h00FF, 2'b00);
    expect_ev(K_DN, 16'h0, 16'd4, 2'b00);
    start_instr(16'h1049, 16'h0000);
    finish_instr("rrc_b_reg", 20);

    // R3 operand is illegal
    expect_ev(K_DN, 16'h0, 16'd1, 2'b01);
    start_instr(16'h1103, 16'h0000);
    finish_instr("r3_ill", 10);

    // Asynchronous reset while a read request is pending
    mem_wait = 20;
    start_instr(16'h10AA, 16'h0000);
    n = 0;
    while (!MEM_REQ && n < 10) begin
      @(negedge CLK);
      n++;
    end
    st_check("rst_memrd_reached", 16'(MEM_REQ), 16'd1);
    #2;
    RST = 1'b1;
    #1;
    st_check("rst_async_drop", {13'h0, MEM_REQ, BUSY, DONE}, 16'h0000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (30) @(negedge CLK);
    #1;
    st_check("rst_quiet", 16'(sb.size()) | 16'(BUSY), 16'd0);
    st_check("rst_r10", rf[10], 16'h0220);
    st_check("rst_mem", mem[10'h110], 16'h0000);

    $display("%0d/%0d checks passed", mon_pass + st_pass, mon_chk + st_chk);
    $finish;
  end

endmodule
